multicycle_alu_control: RTL and testbench

- Multicycle MIPS control FSM. It decodes the latched instruction Opcode/Funct and sequences fetch, decode, execute, memory and writeback.
- It drives ALUCtrl to the datapath ALU, plus all mux, register-file, PC and memory strobes.
- It handshakes with a variable-latency memory port.
- It consumes the ALU Zero flag for branches.

---
 rtl/multicycle_alu_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_alu_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_control.sv
// rtl/multicycle_alu_control.sv - multicycle MIPS control FSM with ALU control decode; ILLEGAL_TRAP_EN makes the illegal-instruction state a terminal trap
module multicycle_alu_control #(
  parameter int CTRL_W = 4
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic [5:0]        Opcode,
  input  logic [5:0]        Funct,
  input  logic              Zero,
  input  logic              MemAck,
  output logic              MemReq,
  output logic              MemWrite,
  output logic              IorD,
  output logic              IRWrite,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic              ZeroExt,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              PCWrite,
  output logic [1:0]        PCSource,
  output logic              Illegal
);

  // ALU operation encodings understood by the datapath ALU
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_ADDU = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SUBU = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_LUI  = 4'b1110;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, RWB, IEXEC, IWB, BRANCH, JUMP, ILL
  } stateT;

  typedef enum logic [2:0] {
    OP_NOP, OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_J, OP_ILL
  } opClassT;

  stateT             state, nextState;
  opClassT           opClass, decClass;
  logic [CTRL_W-1:0] aluOp, decAlu;
  logic              shiftOp, decShift;
  logic              zeroExtQ, decZext;

  // Instruction decode of the IR fields; only consumed while in DECODE
  always_comb begin
    decClass = OP_ILL;
    decAlu   = ALU_AND;
    decShift = 1'b0;
    decZext  = 1'b0;
    case (Opcode)
      6'h23: begin decClass = OP_LW;  decAlu = ALU_ADD; end
      6'h2B: begin decClass = OP_SW;  decAlu = ALU_ADD; end
      6'h04: begin decClass = OP_BEQ; decAlu = ALU_SUB; end
      6'h02: decClass = OP_J;
      OPC_RTYPE: begin
        decClass = OP_RTYPE;
        case (Funct)
          6'h20: decAlu = ALU_ADD;
          6'h21: decAlu = ALU_ADDU;
          6'h22: decAlu = ALU_SUB;
          6'h23: decAlu = ALU_SUBU;
          6'h24: decAlu = ALU_AND;
          6'h25: decAlu = ALU_OR;
          6'h26: decAlu = ALU_XOR;
          6'h27: decAlu = ALU_NOR;
          6'h2A: decAlu = ALU_SLT;
          6'h2B: decAlu = ALU_SLTU;
          6'h00: begin decAlu = ALU_SLL; decShift = 1'b1; end
          6'h02: begin decAlu = ALU_SRL; decShift = 1'b1; end
          6'h03: begin decAlu = ALU_SRA; decShift = 1'b1; end
          // unknown funct still passes through EXEC, then diverts to ILL
          default: decClass = OP_ILL;
        endcase
      end
      6'h08: begin decClass = OP_ITYPE; decAlu = ALU_ADD;  end
      6'h09: begin decClass = OP_ITYPE; decAlu = ALU_ADDU; end
      6'h0A: begin decClass = OP_ITYPE; decAlu = ALU_SLT;  end
      6'h0B: begin decClass = OP_ITYPE; decAlu = ALU_SLTU; end
      6'h0C: begin decClass = OP_ITYPE; decAlu = ALU_AND; decZext = 1'b1; end
      6'h0D: begin decClass = OP_ITYPE; decAlu = ALU_OR;  decZext = 1'b1; end
      6'h0E: begin decClass = OP_ITYPE; decAlu = ALU_XOR; decZext = 1'b1; end
      6'h0F: begin decClass = OP_ITYPE; decAlu = ALU_LUI; end
      default: decClass = OP_ILL;
    endcase
  end

  // State register; async reset drops every Moore output immediately
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Op-class and ALU setup captured in DECODE so later states need not watch the IR
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      opClass  <= OP_NOP;
      aluOp    <= ALU_AND;
      shiftOp  <= 1'b0;
      zeroExtQ <= 1'b0;
    end else if (state == DECODE) begin
      opClass  <= decClass;
      aluOp    <= decAlu;
      shiftOp  <= decShift;
      zeroExtQ <= decZext;
    end
  end

  // Next-state and output decode; anything not set in a state stays 0
  always_comb begin
    nextState = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    ZeroExt   = 1'b0;
    ALUCtrl   = ALU_AND;
    PCWrite   = 1'b0;
    PCSource  = 2'd0;
    Illegal   = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'd1;
        ALUCtrl = ALU_ADD;
        // PC+4 and IR load happen in the cycle the fetch completes
        if (MemAck) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        ALUCtrl = ALU_ADD;
        if (Opcode == OPC_RTYPE) begin
          nextState = EXEC;
        end else begin
          case (decClass)
            OP_LW, OP_SW: nextState = MEMADR;
            OP_ITYPE:     nextState = IEXEC;
            OP_BEQ:       nextState = BRANCH;
            OP_J:         nextState = JUMP;
            default:      nextState = ILL;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ALUCtrl   = ALU_ADD;
        nextState = (opClass == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemAck) nextState = MEMWB;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemAck) nextState = FETCH;
      end
      EXEC: begin
        ALUSrcA   = shiftOp ? 2'd2 : 2'd1;
        ALUCtrl   = aluOp;
        nextState = (opClass == OP_ILL) ? ILL : RWB;
      end
      RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        ALUCtrl   = aluOp;
        nextState = FETCH;
      end
      IEXEC: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ALUCtrl   = aluOp;
        ZeroExt   = zeroExtQ;
        nextState = IWB;
      end
      IWB: begin
        RegWrite  = 1'b1;
        ALUCtrl   = aluOp;
        ZeroExt   = zeroExtQ;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'd1;
        ALUCtrl   = ALU_SUB;
        PCSource  = 2'd1;
        PCWrite   = Zero;
        nextState = FETCH;
      end
      JUMP: begin
        PCSource  = 2'd2;
        PCWrite   = 1'b1;
        nextState = FETCH;
      end
      ILL: begin
`ifdef ILLEGAL_TRAP_EN
        Illegal   = 1'b1;
        nextState = ILL;
`else
        nextState = FETCH;
`endif
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_alu_control.sv
// tb/tb_multicycle_alu_control.sv - directed table-driven bench for multicycle_alu_control
module tb_multicycle_alu_control;

  logic       CLK = 1'b0;
  logic       Reset_L = 1'b0;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       MemAck = 1'b0;
  logic       MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource;
  logic       ZeroExt, PCWrite, Illegal;
  logic [3:0] ALUCtrl;

  multicycle_alu_control #(.CTRL_W(4)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemAck(MemAck), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUCtrl(ALUCtrl),
    .PCWrite(PCWrite), .PCSource(PCSource), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  wire [19:0] outs = {MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, ZeroExt, ALUCtrl, PCWrite, PCSource, Illegal};

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    int          lat;
    logic [19:0] c2;
    logic [19:0] c3;
  } vecT;

  vecT vecs[14];

  function automatic logic [19:0] mk(input logic mr, input logic mw, input logic iord,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic ze, input logic [3:0] alu, input logic pcw,
                                     input logic [1:0] pcs, input logic ill);
    return {mr, mw, iord, irw, rd, m2r, rw, sa, sb, ze, alu, pcw, pcs, ill};
  endfunction

  function automatic logic [19:0] exR(input logic [1:0] sa, input logic [3:0] alu);
    return mk(0,0,0,0,0,0,0, sa, 2'd0, 0, alu, 0, 2'd0, 0);
  endfunction
  function automatic logic [19:0] wbR(input logic [3:0] alu);
    return mk(0,0,0,0,1,0,1, 2'd0, 2'd0, 0, alu, 0, 2'd0, 0);
  endfunction
  function automatic logic [19:0] exI(input logic ze, input logic [3:0] alu);
    return mk(0,0,0,0,0,0,0, 2'd1, 2'd2, ze, alu, 0, 2'd0, 0);
  endfunction
  function automatic logic [19:0] wbI(input logic ze, input logic [3:0] alu);
    return mk(0,0,0,0,0,0,1, 2'd0, 2'd0, ze, alu, 0, 2'd0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [19:0] fetchWait, fetchAck, decodeOut, memAdr, memRd, memWr, memWb;
  int          cyc, reqCnt;
  logic [19:0] got2, got3;

  initial begin
    fetchWait = mk(1,0,0,0,0,0,0, 2'd0, 2'd1, 0, 4'b0010, 0, 2'd0, 0);
    fetchAck  = mk(1,0,0,1,0,0,0, 2'd0, 2'd1, 0, 4'b0010, 1, 2'd0, 0);
    decodeOut = mk(0,0,0,0,0,0,0, 2'd0, 2'd3, 0, 4'b0010, 0, 2'd0, 0);
    memAdr    = mk(0,0,0,0,0,0,0, 2'd1, 2'd2, 0, 4'b0010, 0, 2'd0, 0);
    memRd     = mk(1,0,1,0,0,0,0, 2'd0, 2'd0, 0, 4'b0000, 0, 2'd0, 0);
    memWr     = mk(1,1,1,0,0,0,0, 2'd0, 2'd0, 0, 4'b0000, 0, 2'd0, 0);
    memWb     = mk(0,0,0,0,0,1,1, 2'd0, 2'd0, 0, 4'b0000, 0, 2'd0, 0);

    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, exR(2'd1, 4'b0010), wbR(4'b0010)};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, exR(2'd1, 4'b0110), wbR(4'b0110)};
    vecs[2]  = '{6'h00, 6'h03, 1'b0, 4, exR(2'd2, 4'b1101), wbR(4'b1101)};
    vecs[3]  = '{6'h00, 6'h27, 1'b0, 4, exR(2'd1, 4'b1100), wbR(4'b1100)};
    vecs[4]  = '{6'h00, 6'h2B, 1'b0, 4, exR(2'd1, 4'b1011), wbR(4'b1011)};
    vecs[5]  = '{6'h0F, 6'h00, 1'b0, 4, exI(1'b0, 4'b1110), wbI(1'b0, 4'b1110)};
    vecs[6]  = '{6'h0D, 6'h00, 1'b0, 4, exI(1'b1, 4'b0001), wbI(1'b1, 4'b0001)};
    vecs[7]  = '{6'h0A, 6'h00, 1'b0, 4, exI(1'b0, 4'b0111), wbI(1'b0, 4'b0111)};
    vecs[8]  = '{6'h2B, 6'h00, 1'b0, 4, memAdr, memWr};
    vecs[9]  = '{6'h23, 6'h00, 1'b0, 5, memAdr, memRd};
    vecs[10] = '{6'h04, 6'h00, 1'b1, 3, mk(0,0,0,0,0,0,0, 2'd1, 2'd0, 0, 4'b0110, 1, 2'd1, 0), fetchAck};
    vecs[11] = '{6'h04, 6'h00, 1'b0, 3, mk(0,0,0,0,0,0,0, 2'd1, 2'd0, 0, 4'b0110, 0, 2'd1, 0), fetchAck};
    vecs[12] = '{6'h02, 6'h00, 1'b0, 3, mk(0,0,0,0,0,0,0, 2'd0, 2'd0, 0, 4'b0000, 1, 2'd2, 0), fetchAck};
    vecs[13] = '{6'h3F, 6'h00, 1'b0, 3, 20'h0, fetchAck};

    // reset, idle, fetch wait/complete, decode
    tick();
    tick();
    check("reset_outs", outs, 20'h0);
    Reset_L = 1'b1;
    #1;
    check("idle_outs", outs, 20'h0);
    tick();
    check("fetch_wait", outs, fetchWait);
    tick();
    check("fetch_hold", outs, fetchWait);
    MemAck = 1'b1;
    Opcode = 6'h02;
    #1;
    check("fetch_ack", outs, fetchAck);
    tick();
    check("decode_outs", outs, decodeOut);
    tick();
    tick();
    check("back_to_fetch", {31'd0, MemReq && !IorD}, 32'd1);

    // table of single instructions, memory always acknowledging immediately
    for (int i = 0; i < 14; i++) begin
      Opcode = vecs[i].op;
      Funct  = vecs[i].fn;
      Zero   = vecs[i].zero;
      MemAck = 1'b1;
      cyc = 0;
      got2 = '0;
      got3 = '0;
      do begin
        tick();
        cyc++;
        if (cyc == 2) got2 = outs;
        if (cyc == 3) got3 = outs;
      end while (!(MemReq && !IorD) && cyc < 20);
      check($sformatf("vec%0d_cycle2", i), {12'd0, got2}, {12'd0, vecs[i].c2});
      check($sformatf("vec%0d_cycle3", i), {12'd0, got3}, {12'd0, vecs[i].c3});
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
    end

    // lw with three wait cycles in MEMRD
    Opcode = 6'h23;
    Zero = 1'b0;
    MemAck = 1'b1;
    cyc = 0;
    tick();
    cyc++;
    MemAck = 1'b0;
    tick();
    cyc++;
    tick();
    cyc++;
    reqCnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemAck = 1'b1;
      #1;
      if (MemReq && IorD) reqCnt++;
      tick();
      cyc++;
    end
    check("lw_req_cycles", reqCnt, 4);
    check("lw_memwb", {12'd0, outs}, {12'd0, memWb});
    tick();
    cyc++;
    check("lw_total_8", {31'd0, MemReq && !IorD}, 32'd1);
    check("lw_cycle_count", cyc, 8);

    // reset asserted in the middle of MEMRD
    Opcode = 6'h23;
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    tick();
    tick();
    check("memrd_req", {31'd0, MemReq}, 32'd1);
    Reset_L = 1'b0;
    #1;
    check("async_reset_outs", outs, 20'h0);
    tick();
    check("held_reset_outs", outs, 20'h0);
    Reset_L = 1'b1;
    #1;
    check("post_reset_idle", outs, 20'h0);
    tick();
    check("post_reset_fetch", outs, fetchWait);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
